// File: rtl/Pipe_Ctrl_PKG.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the controller state encoding, the all-zero NOP entry loaded on a
// flush, and the register-match helper used by the hazard detector.
package Pipe_Ctrl_PKG;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_ctrl_state_t;

  localparam int REG_ADDR_W = 5;
  localparam int INSTR_W    = 32;
  localparam int NUM_SRC    = 2;

  // Value a pipeline buffer register takes when its flush is asserted.
  localparam logic [INSTR_W-1:0] NOP_ENTRY = '0;

  // A source register depends on a producer when the producer writes the
  // register file, targets the same register, and that register is not x0.
  function automatic logic reg_match(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  regwrite
  );
    return regwrite && (rd != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational read-after-write hazard detector for the ID stage.
// Build option PIPE_FWD_EN: when defined, forwarding paths exist and only a
// load in ID/EX feeding the instruction in IF/ID needs a stall. When
// undefined, any in-flight producer in ID/EX, EX/MEM or MEM/WB stalls the
// consumer until the producer has retired, since the register file does not
// bypass a same-cycle write to a read.
module raw_hazard_detect
  import Pipe_Ctrl_PKG::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       idex_memread,
  input  logic       idex_regwrite,
  input  logic [4:0] idex_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_rd,
  output logic       stall
);

  logic [REG_ADDR_W-1:0] src [NUM_SRC];
  logic [NUM_SRC-1:0]    idex_hit;
  logic [NUM_SRC-1:0]    exmem_hit;
  logic [NUM_SRC-1:0]    memwb_hit;

  assign src[0] = id_rs1;
  assign src[1] = id_rs2;

  // Per-source comparison against every downstream producer.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign idex_hit[gi]  = reg_match(src[gi], idex_rd,  idex_regwrite);
    assign exmem_hit[gi] = reg_match(src[gi], exmem_rd, exmem_regwrite);
    assign memwb_hit[gi] = reg_match(src[gi], memwb_rd, memwb_regwrite);
  end

`ifdef PIPE_FWD_EN
  // Only the load-use case cannot be covered by forwarding.
  assign stall = idex_memread && (|idex_hit);

  logic unused_fwd;
  assign unused_fwd = ^{exmem_hit, memwb_hit};
`else
  // Without forwarding every pending write blocks the reader.
  assign stall = (|idex_hit) || (|exmem_hit) || (|memwb_hit);

  logic unused_memread;
  assign unused_memread = idex_memread;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencing controller for a 5-stage pipeline.
// Produces every pipeline-register write-enable and flush: stalls on RAW
// hazards, flushes the wrong path on a taken branch, freezes while data
// memory is busy, and drains then stops the core on a halt instruction.
// Build option PIPE_FWD_EN selects the forwarding-aware hazard rule inside
// raw_hazard_detect.
module pipe_hazard_ctrl
  import Pipe_Ctrl_PKG::*;
#(
  parameter int STALL_CNT_W  = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   idex_memread,
  input  logic                   idex_regwrite,
  input  logic                   idex_halt,
  input  logic [4:0]             idex_rd,
  input  logic                   exmem_regwrite,
  input  logic                   exmem_memacc,
  input  logic [4:0]             exmem_rd,
  input  logic                   memwb_regwrite,
  input  logic [4:0]             memwb_rd,
  input  logic                   branch_taken,
  input  logic                   dmem_ready,
  output logic                   pc_we,
  output logic                   ifid_we,
  output logic                   idex_we,
  output logic                   exmem_we,
  output logic                   memwb_we,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   memwb_bubble,
  output logic                   dmem_req,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

  pipe_ctrl_state_t       state_reg;
  pipe_ctrl_state_t       state_next;
  logic [DRAIN_W-1:0]     drain_cnt_reg;
  logic [DRAIN_W-1:0]     drain_cnt_next;
  logic                   drain_wait_reg;
  logic                   drain_wait_next;
  logic                   halted_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  logic hazard_stall;
  logic run_mem_stall;
  logic drain_req;
  logic drain_freeze;

  raw_hazard_detect u_hazard (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .idex_memread   (idex_memread),
    .idex_regwrite  (idex_regwrite),
    .idex_rd        (idex_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .stall          (hazard_stall)
  );

  // An access in EX/MEM that memory has not finished this cycle.
  assign run_mem_stall = exmem_memacc && !dmem_ready;

  // Inside the drain the request is kept up once a freeze has started, so a
  // pending access cannot be dropped before memory answers.
  assign drain_req    = exmem_memacc || drain_wait_reg;
  assign drain_freeze = drain_req && !dmem_ready;

  // State register plus drain bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RUN;
      drain_cnt_reg  <= '0;
      drain_wait_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drain_cnt_reg  <= drain_cnt_next;
      drain_wait_reg <= drain_wait_next;
    end
  end

  // Next-state and drain-counter decision.
  always_comb begin
    state_next      = state_reg;
    drain_cnt_next  = drain_cnt_reg;
    drain_wait_next = 1'b0;
    case (state_reg)
      RUN: begin
        if (run_mem_stall) begin
          state_next = MEM_WAIT;
        end else if (idex_halt) begin
          if (DRAIN_CYCLES == 0) begin
            state_next = HALTED;
          end else begin
            state_next     = DRAIN;
            drain_cnt_next = DRAIN_INIT;
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (drain_freeze) begin
          drain_wait_next = 1'b1;
        end else if (drain_cnt_reg <= DRAIN_LAST) begin
          state_next = HALTED;
        end else begin
          drain_cnt_next = drain_cnt_reg - DRAIN_LAST;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Stage enables, flushes and memory request from state and live inputs.
  always_comb begin
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    idex_we      = 1'b0;
    exmem_we     = 1'b0;
    memwb_we     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          dmem_req = exmem_memacc;
          if (run_mem_stall) begin
            memwb_bubble = 1'b1;
          end else if (idex_halt) begin
            ifid_we    = 1'b1;
            idex_we    = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (branch_taken) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            idex_we    = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hazard_stall) begin
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
          end else begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
          end else begin
            memwb_bubble = 1'b1;
          end
        end
        DRAIN: begin
          dmem_req = drain_req;
          if (drain_freeze) begin
            memwb_bubble = 1'b1;
          end else begin
            idex_we    = 1'b1;
            idex_flush = 1'b1;
            exmem_we   = 1'b1;
            memwb_we   = 1'b1;
          end
        end
        default: begin
          // HALTED: everything frozen until reset.
        end
      endcase
    end
  end

  // Halt indication, registered from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= (state_next == HALTED);
    end
  end

  // Counts cycles in which the PC is held while the core is still live.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (!pc_we && (state_reg != HALTED)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign halted    = halted_reg;
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run checked against a behavioural model of the controller.
module tb_pipe_hazard_ctrl;

  localparam int DRAIN = 2;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2;
  logic        idex_memread, idex_regwrite, idex_halt;
  logic [4:0]  idex_rd;
  logic        exmem_regwrite, exmem_memacc;
  logic [4:0]  exmem_rd;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic        branch_taken, dmem_ready;
  logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic        ifid_flush, idex_flush, memwb_bubble, dmem_req;
  logic        halted;
  logic [31:0] stall_cnt;

  int tests_run = 0;
  int failed    = 0;

  // Behavioural model: what the controller is currently doing.
  bit          m_waiting;
  bit          m_halted;
  bit          m_drain_hold;
  int          m_drain_left;
  logic [31:0] m_stall;
  logic [8:0]  m_exp;
  logic [8:0]  m_care;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, bubble, req}
  logic [8:0] obs;
  assign obs = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_flush, idex_flush, memwb_bubble, dmem_req};

  pipe_hazard_ctrl #(.STALL_CNT_W(32), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .idex_memread(idex_memread), .idex_regwrite(idex_regwrite),
    .idex_halt(idex_halt), .idex_rd(idex_rd),
    .exmem_regwrite(exmem_regwrite), .exmem_memacc(exmem_memacc),
    .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .dmem_req(dmem_req),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True when a source in IF/ID reads a register still owed by a producer.
  function automatic bit hazard_ref();
    logic [4:0] rd [3];
    bit         wr [3];
    int         n;
    rd[0] = idex_rd;  wr[0] = idex_regwrite;
    rd[1] = exmem_rd; wr[1] = exmem_regwrite;
    rd[2] = memwb_rd; wr[2] = memwb_regwrite;
`ifdef PIPE_FWD_EN
    n = 1;
    if (!idex_memread) return 1'b0;
`else
    n = 3;
`endif
    for (int i = 0; i < n; i++) begin
      if (wr[i] && rd[i] != 5'd0 && (rd[i] == id_rs1 || rd[i] == id_rs2))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected combinational outputs (and which of them are defined).
  task automatic model_eval();
    bit req;
    m_exp  = '0;
    m_care = '0;
    if (reset) begin
      m_exp = 9'b00000_1100; m_care = 9'b11111_1101;
    end else if (m_halted) begin
      m_care = 9'b11111_0000;
    end else if (m_waiting) begin
      m_exp  = dmem_ready ? 9'b11111_0001 : 9'b00000_0011;
      m_care = '1;
    end else if (m_drain_left > 0) begin
      req = exmem_memacc || m_drain_hold;
      if (req && !dmem_ready) begin
        m_exp = 9'b00000_0011; m_care = 9'b11111_0011;
      end else begin
        m_exp = {5'b00011, 3'b010, req}; m_care = 9'b11011_0111;
      end
    end else begin
      req = exmem_memacc;
      if (exmem_memacc && !dmem_ready) begin
        m_exp = 9'b00000_0011; m_care = 9'b11111_0011;
      end else if (idex_halt) begin
        m_exp = {5'b00011, 3'b110, req}; m_care = 9'b10011_1111;
      end else if (branch_taken) begin
        m_exp = {5'b10011, 3'b110, req}; m_care = 9'b10011_1111;
      end else if (hazard_ref()) begin
        m_exp = {5'b00011, 3'b010, req}; m_care = 9'b11011_0111;
      end else begin
        m_exp = {5'b11111, 3'b000, req}; m_care = '1;
      end
    end
  endtask

  // Model reaction to a clock edge.
  task automatic model_advance();
    if (reset) begin
      m_waiting = 0; m_halted = 0; m_drain_hold = 0; m_drain_left = 0;
      m_stall = '0;
    end else begin
      if (!m_halted && m_exp[8] == 1'b0) m_stall = m_stall + 32'd1;
      if (m_halted) begin
        m_halted = 1;
      end else if (m_waiting) begin
        if (dmem_ready) m_waiting = 0;
      end else if (m_drain_left > 0) begin
        if ((exmem_memacc || m_drain_hold) && !dmem_ready) begin
          m_drain_hold = 1;
        end else begin
          m_drain_hold = 0;
          m_drain_left = m_drain_left - 1;
          if (m_drain_left == 0) m_halted = 1;
        end
      end else if (exmem_memacc && !dmem_ready) begin
        m_waiting = 1;
      end else if (idex_halt) begin
        m_drain_left = DRAIN;
      end
    end
  endtask

  // One clock: inputs were set at the falling edge; returns at the next one.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0;
    idex_memread = 0; idex_regwrite = 0; idex_halt = 0; idex_rd = 0;
    exmem_regwrite = 0; exmem_memacc = 0; exmem_rd = 0;
    memwb_regwrite = 0; memwb_rd = 0;
    branch_taken = 0; dmem_ready = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      exmem_memacc = $urandom_range(0, 1);
      branch_taken = $urandom_range(0, 1);
      dmem_ready   = $urandom_range(0, 1);
      #1;
      tests_run++;
      if ({obs[8:4], obs[3:2], obs[0]} !== 8'b00000_110) begin
        $display("FAIL reset_outputs: got %b required we=00000 flush=11 req=0", obs);
        failed++;
      end
      tick();
      tests_run++;
      if (halted !== 1'b0 || stall_cnt !== 32'd0) begin
        $display("FAIL reset_regs: halted=%b stall_cnt=%0d required 0/0", halted, stall_cnt);
        failed++;
      end
      $display("[TB] reset cycle %0d out=%b halted=%b", c, obs, halted);
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [3:0] exp_pc;
    int         stalls;
    int         exp_stalls;
    logic [31:0] start;
`ifdef PIPE_FWD_EN
    exp_pc = 4'b1110; exp_stalls = 1;
`else
    exp_pc = 4'b1000; exp_stalls = 3;
`endif
    clear_inputs();
    start  = m_stall;
    stalls = 0;
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      id_rs1 = 5'd5; id_rs2 = 5'd1;
      if (k == 0) begin idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd5; end
      if (k == 1) begin exmem_regwrite = 1; exmem_rd = 5'd5; exmem_memacc = 1; end
      if (k == 2) begin memwb_regwrite = 1; memwb_rd = 5'd5; end
      #1;
      tests_run++;
      if (pc_we !== exp_pc[k]) begin
        $display("FAIL load_use_pc_we[%0d]: got %b required %b", k, pc_we, exp_pc[k]);
        failed++;
      end
      if (pc_we === 1'b0) begin
        stalls++;
        tests_run++;
        if (idex_flush !== 1'b1 || exmem_we !== 1'b1 || memwb_we !== 1'b1) begin
          $display("FAIL load_use_bubble[%0d]: idex_flush=%b exmem_we=%b memwb_we=%b required 1/1/1",
                   k, idex_flush, exmem_we, memwb_we);
          failed++;
        end
      end
      $display("[TB] load_use cycle %0d out=%b", k, obs);
      tick();
    end
    tests_run++;
    if (stalls != exp_stalls) begin
      $display("FAIL load_use_count: got %0d stall cycles required %0d", stalls, exp_stalls);
      failed++;
    end
    tests_run++;
    if (stall_cnt !== start + 32'(exp_stalls)) begin
      $display("FAIL load_use_stall_cnt: got %0d required %0d", stall_cnt, start + 32'(exp_stalls));
      failed++;
    end
    clear_inputs();
  endtask

  task automatic test_x0();
    clear_inputs();
    idex_memread = 1; idex_regwrite = 1; idex_rd = 0;
    exmem_regwrite = 1; exmem_rd = 0;
    memwb_regwrite = 1; memwb_rd = 0;
    id_rs1 = 0; id_rs2 = 0;
    #1;
    tests_run++;
    if (pc_we !== 1'b1 || idex_flush !== 1'b0) begin
      $display("FAIL x0_no_stall: pc_we=%b idex_flush=%b required 1/0", pc_we, idex_flush);
      failed++;
    end
    $display("[TB] x0 producer out=%b", obs);
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_over_stall();
    logic [31:0] start;
    clear_inputs();
    start = m_stall;
    idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd7; id_rs2 = 5'd7;
    branch_taken = 1;
    #1;
    tests_run++;
    if (pc_we !== 1'b1 || ifid_flush !== 1'b1 || idex_flush !== 1'b1) begin
      $display("FAIL branch_override: pc_we=%b ifid_flush=%b idex_flush=%b required 1/1/1",
               pc_we, ifid_flush, idex_flush);
      failed++;
    end
    $display("[TB] branch over stall out=%b", obs);
    tick();
    tests_run++;
    if (stall_cnt !== start) begin
      $display("FAIL branch_stall_cnt: got %0d required %0d", stall_cnt, start);
      failed++;
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    logic [31:0] start;
    clear_inputs();
    start = m_stall;
    exmem_memacc = 1;
    for (int k = 0; k < 4; k++) begin
      dmem_ready = (k == 3);
      #1;
      tests_run++;
      if (k < 3 && obs !== 9'b00000_0011) begin
        $display("FAIL mem_freeze[%0d]: got %b required 000000011", k, obs);
        failed++;
      end else if (k == 3 && ({obs[8:4], obs[0]} !== 6'b11111_1)) begin
        $display("FAIL mem_ready: got %b required we=11111 req=1", obs);
        failed++;
      end
      $display("[TB] mem_wait cycle %0d ready=%b out=%b", k, dmem_ready, obs);
      tick();
    end
    tests_run++;
    if (stall_cnt !== start + 32'd3) begin
      $display("FAIL mem_stall_cnt: got %0d required %0d", stall_cnt, start + 32'd3);
      failed++;
    end
    clear_inputs();
    #1;
    tests_run++;
    if (pc_we !== 1'b1 || dmem_req !== 1'b0) begin
      $display("FAIL mem_resume: pc_we=%b dmem_req=%b required 1/0", pc_we, dmem_req);
      failed++;
    end
    tick();
  endtask

  task automatic test_halt();
    clear_inputs();
    for (int k = 0; k < 3; k++) begin
      idex_halt = (k == 0);
      #1;
      tests_run++;
      if (pc_we !== 1'b0 || exmem_we !== 1'b1 || memwb_we !== 1'b1) begin
        $display("FAIL halt_drain[%0d]: pc_we=%b exmem_we=%b memwb_we=%b required 0/1/1",
                 k, pc_we, exmem_we, memwb_we);
        failed++;
      end
      tick();
      tests_run++;
      if (halted !== (k == 2)) begin
        $display("FAIL halt_timing[%0d]: halted=%b required %b", k, halted, (k == 2));
        failed++;
      end
      $display("[TB] halt cycle %0d out=%b halted=%b", k, obs, halted);
    end
    for (int k = 0; k < 4; k++) begin
      idex_halt    = $urandom_range(0, 1);
      branch_taken = $urandom_range(0, 1);
      exmem_memacc = $urandom_range(0, 1);
      #1;
      tests_run++;
      if (obs[8:4] !== 5'b00000) begin
        $display("FAIL halted_frozen[%0d]: we=%b required 00000", k, obs[8:4]);
        failed++;
      end
      tick();
      tests_run++;
      if (halted !== 1'b1 || stall_cnt !== m_stall) begin
        $display("FAIL halted_sticky[%0d]: halted=%b stall_cnt=%0d required 1/%0d",
                 k, halted, stall_cnt, m_stall);
        failed++;
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_drain();
    clear_inputs();
    reset = 1; tick(); reset = 0;
    idex_halt = 1; tick(); idex_halt = 0;
    tick();
    reset = 1;
    exmem_memacc = 1; dmem_ready = 0;
    #1;
    tests_run++;
    if (obs[8:4] !== 5'b00000 || dmem_req !== 1'b0) begin
      $display("FAIL drain_reset_out: we=%b dmem_req=%b required 00000/0", obs[8:4], dmem_req);
      failed++;
    end
    tick();
    tests_run++;
    if (halted !== 1'b0 || stall_cnt !== 32'd0) begin
      $display("FAIL drain_reset_regs: halted=%b stall_cnt=%0d required 0/0", halted, stall_cnt);
      failed++;
    end
    reset = 0;
    clear_inputs();
    #1;
    tests_run++;
    if (dmem_req !== 1'b0 || pc_we !== 1'b1) begin
      $display("FAIL drain_reset_run: dmem_req=%b pc_we=%b required 0/1", dmem_req, pc_we);
      failed++;
    end
    $display("[TB] reset in drain out=%b halted=%b", obs, halted);
    tick();
  endtask

  task automatic test_random();
    clear_inputs();
    reset = 1; tick(); reset = 0;
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 49) == 0);
      id_rs1         = 5'($urandom_range(0, 7));
      id_rs2         = 5'($urandom_range(0, 7));
      idex_memread   = $urandom_range(0, 1);
      idex_regwrite  = $urandom_range(0, 1);
      idex_halt      = ($urandom_range(0, 24) == 0);
      idex_rd        = 5'($urandom_range(0, 7));
      exmem_regwrite = $urandom_range(0, 1);
      exmem_memacc   = ($urandom_range(0, 2) == 0);
      exmem_rd       = 5'($urandom_range(0, 7));
      memwb_regwrite = $urandom_range(0, 1);
      memwb_rd       = 5'($urandom_range(0, 7));
      branch_taken   = ($urandom_range(0, 4) == 0);
      dmem_ready     = $urandom_range(0, 1);
      #1;
      model_eval();
      tests_run++;
      if ((obs & m_care) !== (m_exp & m_care)) begin
        $display("FAIL rnd_outputs[%0d]: got %b required %b (mask %b)", n, obs, m_exp, m_care);
        failed++;
      end
      $display("[TB] rnd %0d rst=%b halt=%b br=%b acc=%b rdy=%b out=%b", n, reset, idex_halt,
               branch_taken, exmem_memacc, dmem_ready, obs);
      tick();
      tests_run++;
      if (halted !== m_halted || stall_cnt !== m_stall) begin
        $display("FAIL rnd_regs[%0d]: halted=%b stall_cnt=%0d required %b/%0d",
                 n, halted, stall_cnt, m_halted, m_stall);
        failed++;
      end
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    m_waiting = 0; m_halted = 0; m_drain_hold = 0; m_drain_left = 0;
    m_stall = '0; m_exp = '0; m_care = '0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_x0();
    test_branch_over_stall();
    test_mem_wait();
    test_halt();
    test_reset_in_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
